dpram_stream_reader: RTL and testbench

DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

---
 rtl/dpram_stream_reader.sv | 139 +++++++++++++
 tb/tb_dpram_stream_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Burst reader: streams a run of consecutive RAM words (with address wrap) out
// through a 2-entry skid buffer, issuing reads only when buffer space is certain.
//
// state | meaning
// IDLE  | waiting for start; zero-length start answers with done only
// READ  | issuing reads, one per cycle at most
// DRAIN | all reads issued, delivering the remaining buffered words
module dpram_stream_reader #(
   parameter int AWIDTH    = 11,
   parameter int DWIDTH    = 60,
   parameter int NUM_WORDS = 2048
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [AWIDTH:0]   num_words,
   output logic              busy,
   output logic              done,
   output logic [AWIDTH-1:0] ram_addr,
   output logic              ram_wren,
   input  logic [DWIDTH-1:0] ram_rdata,
   output logic [DWIDTH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state;
   logic [AWIDTH-1:0] nxt_addr;
   logic [AWIDTH-1:0] last_addr;
   logic [AWIDTH-1:0] addr_inc;
   logic [AWIDTH:0]   issue_left;
   logic [AWIDTH:0]   xfer_left;
   logic              rd_pend;
   logic [DWIDTH-1:0] buf0;
   logic [DWIDTH-1:0] buf1;
   logic [1:0]        buf_cnt;
   logic [1:0]        occ_after_pop;
   logic              rd_issue;
   logic              pop;

   assign out_valid = (buf_cnt != 2'd0);
   assign out_data  = buf0;
   assign pop       = out_valid & out_ready;
   assign ram_wren  = 1'b0;

   // Counting the word leaving this cycle lets a read go out every cycle at full rate.
   assign occ_after_pop = buf_cnt + 2'(rd_pend) - 2'(pop);
   assign rd_issue      = (state == READ) && (occ_after_pop < 2'd2);

   // The address is presented in the issue cycle so the registered RAM returns it next cycle.
   assign ram_addr = rd_issue ? nxt_addr : last_addr;
   assign addr_inc = (nxt_addr == AWIDTH'(NUM_WORDS - 1)) ? '0 : nxt_addr + 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         nxt_addr   <= '0;
         last_addr  <= '0;
         issue_left <= '0;
         xfer_left  <= '0;
         rd_pend    <= 1'b0;
      end else begin
         done    <= 1'b0;
         rd_pend <= rd_issue;
         if (rd_issue) begin
            last_addr  <= nxt_addr;
            nxt_addr   <= addr_inc;
            issue_left <= issue_left - 1'b1;
         end
         if (pop) begin
            xfer_left <= xfer_left - 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words != '0) begin
                     state      <= READ;
                     busy       <= 1'b1;
                     nxt_addr   <= base_addr;
                     issue_left <= num_words;
                     xfer_left  <= num_words;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rd_issue && issue_left == 1) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop && xfer_left == 1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Skid buffer: buf0 is the head; rd_pend marks ram_rdata as valid this cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf0    <= '0;
         buf1    <= '0;
         buf_cnt <= 2'd0;
      end else begin
         case ({rd_pend, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) buf0 <= ram_rdata;
               else                 buf1 <= ram_rdata;
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b01: begin
               buf0    <= buf1;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf0 <= ram_rdata;
               end else begin
                  buf0 <= buf1;
                  buf1 <= ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: registered-read RAM model holding
// RAM[i]=i, scenario tasks with hand-computed expectations.
module tb_dpram_stream_reader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [10:0] base_addr = '0;
   logic [11:0] num_words = '0;
   logic        busy;
   logic        done;
   logic [10:0] ram_addr;
   logic        ram_wren;
   logic [59:0] ram_rdata;
   logic [59:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [59:0] mem [2048];

   dpram_stream_reader #(.AWIDTH(11), .DWIDTH(60), .NUM_WORDS(2048)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .busy      (busy),
      .done      (done),
      .ram_addr  (ram_addr),
      .ram_wren  (ram_wren),
      .ram_rdata (ram_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 60'(i);
      ram_rdata = '0;
   end

   always @(posedge clk) ram_rdata <= mem[ram_addr];

   // Leaves the caller 1 time unit after the negedge of the first cycle after the start edge.
   task automatic do_start(input int base, input int len);
      @(negedge clk);
      start     = 1'b1;
      base_addr = 11'(base);
      num_words = 12'(len);
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      vectors++; if (ram_addr !== 11'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
      vectors++; if (out_data !== 60'd0) begin miscompares++; $display("FAIL reset_data: got %0d expected 0", out_data); end
      vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b expected 0", ram_wren); end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      do_start(5, 4);
      vectors++; if (ram_addr !== 11'd5) begin miscompares++; $display("FAIL basic_first_addr: got %0d expected 5", ram_addr); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", busy); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_c1_valid: got %b expected 0", out_valid); end
      step;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_c2_valid: got %b expected 0", out_valid); end
      for (int i = 0; i < 4; i++) begin
         step;
         vectors++;
         if (out_valid !== 1'b1 || out_data !== 60'(5 + i) || done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_word%0d: got valid=%b data=%0d done=%b expected valid=1 data=%0d done=0",
                     i, out_valid, out_data, done, 5 + i);
         end
      end
      step;
      vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_after_valid: got %b expected 0", out_valid); end
      step;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b expected 0", done); end
   endtask

   task automatic test_wrap;
      int ea[6];
      int ed[4];
      ea = '{2046, 2047, 0, 1, 1, 1};
      ed = '{2046, 2047, 0, 1};
      out_ready = 1'b1;
      do_start(2046, 4);
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) step;
         vectors++;
         if (ram_addr !== 11'(ea[c-1])) begin
            miscompares++;
            $display("FAIL wrap_addr_c%0d: got %0d expected %0d", c, ram_addr, ea[c-1]);
         end
         if (c >= 3) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 60'(ed[c-3])) begin
               miscompares++;
               $display("FAIL wrap_data_c%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                        c, out_valid, out_data, ed[c-3]);
            end
         end
      end
      step;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done: got %b expected 1", done); end
   endtask

   task automatic test_backpressure;
      bit          pat[6];
      int          n_xfer, n_issue;
      logic [10:0] prev_addr;
      logic [59:0] prev_data;
      bit          prev_stall, got_done;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n_xfer = 0; n_issue = 0; prev_stall = 1'b0; got_done = 1'b0; prev_data = '0;
      prev_addr = ram_addr;
      out_ready = 1'b1;
      do_start(20, 6);
      for (int k = 1; k <= 80; k++) begin
         if (k > 1) @(negedge clk);
         out_ready = pat[(k - 1) % 6];
         if (k == 3) begin
            start = 1'b1; base_addr = 11'd500; num_words = 12'd3;
         end
         if (k == 4) start = 1'b0;
         #1;
         if (ram_addr !== prev_addr) begin
            n_issue++;
            prev_addr = ram_addr;
         end
         if (prev_stall) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               miscompares++;
               $display("FAIL bp_stall_hold_k%0d: got valid=%b data=%0d expected valid=1 data=%0d",
                        k, out_valid, out_data, prev_data);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (out_data !== 60'(20 + n_xfer)) begin
               miscompares++;
               $display("FAIL bp_word%0d: got %0d expected %0d", n_xfer, out_data, 20 + n_xfer);
            end
            n_xfer++;
         end
         vectors++;
         if (n_issue - n_xfer > 2) begin
            miscompares++;
            $display("FAIL bp_occupancy_k%0d: got %0d words held expected at most 2", k, n_issue - n_xfer);
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_data  = out_data;
         if (done === 1'b1) begin
            got_done = 1'b1;
            break;
         end
      end
      vectors++; if (!got_done) begin miscompares++; $display("FAIL bp_done_timeout: got no done expected done"); end
      vectors++; if (n_xfer != 6) begin miscompares++; $display("FAIL bp_xfer_count: got %0d expected 6", n_xfer); end
      vectors++; if (n_issue != 6) begin miscompares++; $display("FAIL bp_issue_count: got %0d expected 6", n_issue); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_busy_end: got %b expected 0", busy); end
      out_ready = 1'b1;
      repeat (3) step;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_ignored_start: got busy=%b valid=%b expected busy=0 valid=0", busy, out_valid);
      end
   endtask

   task automatic test_zero_len;
      logic [10:0] pa;
      out_ready = 1'b1;
      pa = ram_addr;
      do_start(7, 0);
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b expected 1", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy: got %b expected 0", busy); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_valid: got %b expected 0", out_valid); end
      vectors++; if (ram_addr !== pa) begin miscompares++; $display("FAIL zero_addr: got %0d expected %0d", ram_addr, pa); end
      for (int c = 0; c < 3; c++) begin
         step;
         vectors++;
         if (done !== 1'b0 || out_valid !== 1'b0 || ram_addr !== pa) begin
            miscompares++;
            $display("FAIL zero_quiet_c%0d: got done=%b valid=%b addr=%0d expected done=0 valid=0 addr=%0d",
                     c, done, out_valid, ram_addr, pa);
         end
      end
   endtask

   task automatic test_full;
      int n, first, done_k;
      n = 0; first = -1; done_k = -1;
      out_ready = 1'b1;
      do_start(0, 2048);
      for (int k = 1; k <= 2200; k++) begin
         if (k > 1) step;
         if (out_valid === 1'b1) begin
            if (first < 0) first = k;
            vectors++;
            if (out_data !== 60'(n)) begin
               miscompares++;
               $display("FAIL full_word%0d: got %0d expected %0d", n, out_data, n);
            end
            n++;
         end
         if (done === 1'b1) begin
            done_k = k;
            break;
         end
      end
      vectors++; if (done_k < 0) begin miscompares++; $display("FAIL full_done_timeout: got no done expected done"); end
      vectors++; if (n != 2048) begin miscompares++; $display("FAIL full_count: got %0d expected 2048", n); end
      vectors++; if (first != 3) begin miscompares++; $display("FAIL full_first_valid: got cycle %0d expected 3", first); end
      vectors++; if (done_k != 2051) begin miscompares++; $display("FAIL full_done_cycle: got %0d expected 2051", done_k); end
   endtask

   task automatic test_reset_abort;
      int n, n2, done_seen, done_k;
      n = 0; n2 = 0; done_seen = 0; done_k = -1;
      out_ready = 1'b1;
      do_start(40, 8);
      for (int k = 1; k <= 20 && n < 3; k++) begin
         if (k > 1) step;
         if (out_valid === 1'b1) begin
            vectors++;
            if (out_data !== 60'(40 + n)) begin
               miscompares++;
               $display("FAIL abort_word%0d: got %0d expected %0d", n, out_data, 40 + n);
            end
            n++;
         end
      end
      @(negedge clk);
      resetn = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || ram_addr !== 11'd0 || out_data !== 60'd0) begin
         miscompares++;
         $display("FAIL abort_async: got busy=%b done=%b valid=%b addr=%0d data=%0d expected all 0",
                  busy, done, out_valid, ram_addr, out_data);
      end
      @(negedge clk);
      @(negedge clk);
      resetn    = 1'b1;
      start     = 1'b1;
      base_addr = 11'd100;
      num_words = 12'd2;
      @(negedge clk);
      start = 1'b0;
      #1;
      for (int k = 1; k <= 12; k++) begin
         if (k > 1) step;
         if (out_valid === 1'b1) begin
            vectors++;
            if (n2 >= 2 || out_data !== 60'(100 + n2)) begin
               miscompares++;
               $display("FAIL abort_new_word%0d: got %0d expected %0d", n2, out_data, 100 + n2);
            end
            n2++;
         end
         if (done === 1'b1) begin
            done_seen++;
            done_k = k;
         end
      end
      vectors++; if (n2 != 2) begin miscompares++; $display("FAIL abort_new_count: got %0d expected 2", n2); end
      vectors++; if (done_seen != 1) begin miscompares++; $display("FAIL abort_done_count: got %0d expected 1", done_seen); end
      vectors++; if (done_k != 5) begin miscompares++; $display("FAIL abort_done_cycle: got %0d expected 5", done_k); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_wrap;
      test_backpressure;
      test_zero_len;
      test_full;
      test_reset_abort;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected bench completion");
      $fatal(1, "bench timeout");
   end

endmodule
